// File: rtl/prog_loader_pkg.sv
// Shared types and RV32I field constants for the program loader and its encoder.
package prog_loader_pkg;

    // Abstract instruction kinds accepted on the loader input stream.
    typedef enum logic [3:0] {
        OP_ADD,
        OP_AND,
        OP_ADDI,
        OP_SLTI,
        OP_SLLI,
        OP_SRLI,
        OP_SRAI,
        OP_LW,
        OP_SW,
        OP_BEQ,
        OP_BNE,
        OP_BLT,
        OP_BGE,
        OP_JAL,
        OP_JALR,
        OP_HALT
    } prog_op_e;

    // Loader FSM states, also exported on the debug port.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HALT_WR,
        ST_DONE
    } loader_state_e;

    // Major opcodes, matching what the control decoder recognises.
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_HALT   = 7'b1111111;

    // funct3 values.
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_SLTI = 3'b010;
    localparam logic [2:0] F3_SLLI = 3'b001;
    localparam logic [2:0] F3_SRxI = 3'b101;
    localparam logic [2:0] F3_LW   = 3'b000;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_JALR = 3'b000;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;

    // funct7 values.
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_SRA  = 7'b0100000;

    // Terminator word written after every program.
    localparam logic [31:0] HALT_WORD = {25'd0, OPC_HALT};

endpackage

// File: rtl/prog_loader_encode.sv
// Combinational encoder: abstract instruction fields to a 32-bit RV32I word.
// Immediates are truncated to whatever bits the format carries.
module rv_encode
    import prog_loader_pkg::*;
(
    input  prog_op_e    op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [20:0] imm,
    output logic [31:0] word
);

    // Place the fields of each format; unknown kinds fall back to HALT.
    always_comb begin
        word = HALT_WORD;
        case (op)
            OP_ADD:  word = {F7_ZERO, rs2, rs1, F3_ADD, rd, OPC_OP};
            OP_AND:  word = {F7_ZERO, rs2, rs1, F3_AND, rd, OPC_OP};
            OP_ADDI: word = {imm[11:0], rs1, F3_ADDI, rd, OPC_OP_IMM};
            OP_SLTI: word = {imm[11:0], rs1, F3_SLTI, rd, OPC_OP_IMM};
            OP_SLLI: word = {F7_ZERO, imm[4:0], rs1, F3_SLLI, rd, OPC_OP_IMM};
            OP_SRLI: word = {F7_ZERO, imm[4:0], rs1, F3_SRxI, rd, OPC_OP_IMM};
            OP_SRAI: word = {F7_SRA, imm[4:0], rs1, F3_SRxI, rd, OPC_OP_IMM};
            OP_LW:   word = {imm[11:0], rs1, F3_LW, rd, OPC_LOAD};
            OP_SW:   word = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OPC_STORE};
            OP_BEQ:  word = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OPC_BRANCH};
            OP_BNE:  word = {imm[12], imm[10:5], rs2, rs1, F3_BNE, imm[4:1], imm[11], OPC_BRANCH};
            OP_BLT:  word = {imm[12], imm[10:5], rs2, rs1, F3_BLT, imm[4:1], imm[11], OPC_BRANCH};
            OP_BGE:  word = {imm[12], imm[10:5], rs2, rs1, F3_BGE, imm[4:1], imm[11], OPC_BRANCH};
            OP_JAL:  word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            OP_JALR: word = {imm[11:0], rs1, F3_JALR, rd, OPC_JALR};
            OP_HALT: word = HALT_WORD;
            default: word = HALT_WORD;
        endcase
    end

endmodule

// File: rtl/prog_loader.sv
// Sequential program loader: encodes a stream of abstract instructions into
// consecutive instruction-memory words from address 0 and always terminates
// the program with a HALT word. The top word of memory is reserved for HALT,
// so an over-long program is truncated and flagged by the sticky overflow bit.
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready.
// in_valid may be asserted at any time; the host must hold the beat fields
// stable while in_valid is high and in_ready is low. in_ready never depends
// combinationally on in_valid (it is a register).
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [20:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output loader_state_e     dbg_state
);

    // Highest word address; it is kept free for the HALT terminator.
    localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};

    loader_state_e     state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   count_inc;
    logic              ovf_d;
    logic              ready_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       wdata_d;
    logic              busy_d;
    logic              done_d;
    logic              accept;
    prog_op_e          beat_op;
    logic [31:0]       enc_word;

    assign beat_op   = prog_op_e'(in_op);
    assign accept    = in_valid && in_ready;
    assign count_inc = count_q + ONE;
    assign dbg_state = state_q;

    rv_encode u_encode (
        .op   (beat_op),
        .rd   (in_rd),
        .rs1  (in_rs1),
        .rs2  (in_rs2),
        .imm  (in_imm),
        .word (enc_word)
    );

    // Next state, next count and the next value of every registered output.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ovf_d   = overflow;
        we_d    = 1'b0;
        addr_d  = imem_addr;
        wdata_d = imem_wdata;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = count_q[ADDR_W-1:0];
                    wdata_d = enc_word;
                    count_d = count_inc;
                    if (beat_op == OP_HALT) begin
                        // The beat itself is the terminator; no extra write.
                        state_d = ST_DONE;
                    end else if (in_last) begin
                        state_d = ST_HALT_WR;
                    end else if (count_inc == LAST_ADDR) begin
                        // Only the reserved word is left: truncate here.
                        state_d = ST_HALT_WR;
                        ovf_d   = 1'b1;
                    end
                end else if (count_q >= LAST_ADDR) begin
                    state_d = ST_HALT_WR;
                    ovf_d   = 1'b1;
                end
            end
            ST_HALT_WR: begin
                we_d    = 1'b1;
                addr_d  = count_q[ADDR_W-1:0];
                wdata_d = HALT_WORD;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_LOAD) && (count_d < LAST_ADDR);
        busy_d  = (state_d == ST_LOAD) || (state_d == ST_HALT_WR);
        // done follows the DONE state one cycle late so it rises as the
        // HALT write completes, and drops together with a restart.
        done_d  = (state_q == ST_DONE) && (state_d == ST_DONE);
    end

    // State, count and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            in_ready   <= ready_d;
            imem_we    <= we_d;
            imem_addr  <= addr_d;
            imem_wdata <= wdata_d;
            busy       <= busy_d;
            done       <= done_d;
            overflow   <= ovf_d;
        end
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

- Sequential program loader that is the write-side counterpart of the main control decoder.
- Accepts a stream of abstract instructions over a valid/ready handshake and encodes each one into a 32-bit RV32I word.
- Writes the words to consecutive instruction-memory addresses starting at 0, then terminates every program with the HALT word (opcode 7'b1111111).
- Sits between the testbench/boot host and the instruction memory.

## Interface
- ADDR_W, 8, instruction-memory word-address width; DEPTH = 2**ADDR_W words.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a new program at address 0. Honoured only in IDLE or DONE.
- in_valid  in  1  instruction beat present.
- in_ready  out  1  loader can accept a beat this cycle.
- in_op  in  4  instruction kind, values from `prog_op_e`.
- in_rd, in_rs1, in_rs2  in  5 each  register fields.
- in_imm  in  21  signed immediate.
- in_last  in  1  marks the final beat of the program.
- imem_we  out  1  write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded word.
- busy  out  1  high in LOAD and HALT_WR.
- done  out  1  held high in DONE.
- overflow  out  1  sticky: program was truncated. Cleared by start.

## Operation
- FSM states and transitions:
  - IDLE: start → LOAD.
  - LOAD: accepted beat with in_last=1 or op=HALT → DONE if op=HALT, otherwise HALT_WR.
  - LOAD: count reaches DEPTH-1 without a terminating beat → HALT_WR and set overflow.
  - HALT_WR → DONE after one cycle.
  - DONE: start → LOAD.
- Inputs are ignored in IDLE, HALT_WR and DONE. start is ignored in LOAD and HALT_WR.
- in_ready = (state==LOAD) && (count < DEPTH-1). Address DEPTH-1 is always reserved for HALT.
- A beat is accepted when in_valid && in_ready. On acceptance, count increments; it is ADDR_W+1 bits wide and never wraps.
- Encodings (standard RV32I field placement; rd/rs fields unused by a format are ignored):
  - R-type: ADD f3=000; AND f3=111.
  - I-type: ADDI 000, SLTI 010, LW 000 (opcode 0000011), JALR 000 (opcode 1100111); imm[11:0].
  - Shifts: SLLI 001 / f7=0000000, SRLI 101 / f7=0000000, SRAI 101 / f7=0100000; shamt=imm[4:0].
  - SW: f3=010.
  - Branches: BEQ 000, BNE 001, BLT 100, BGE 101; imm[12:1], imm[0] ignored.
  - JAL: imm[20:1].
  - HALT: 0x0000007F.
- Immediates are truncated to the field width. No range checking is performed.

## Timing
- Reset values: state IDLE, count 0, in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, busy 0, done 0, overflow 0.
- All outputs are registered. A beat accepted at edge N drives imem_we=1, imem_addr=count, imem_wdata=encoded from edge N until edge N+1, so the write latency is 1 cycle.
- Back-to-back beats sustain one word per cycle.
- The HALT word is written in the cycle after the terminating beat or after the overflow detection. done rises at the edge that ends that write.
- If a beat arrives in the cycle HALT_WR is entered through overflow, it is not accepted because in_ready=0.
- Reset mid-program returns the block to IDLE immediately. Memory contents already written are left as they are.
- start in DONE clears done and overflow, zeroes count, and makes in_ready high the next cycle.

## Structure
- Package `prog_loader_pkg`:
  - `prog_op_e` with 16 values: ADD, AND, ADDI, SLTI, SLLI, SRLI, SRAI, LW, SW, BEQ, BNE, BLT, BGE, JAL, JALR, HALT.
  - Opcode constants identical to those the control decoder matches: 0110011, 0000011, 0100011, 1100011, 0010011, 1101111, 1100111, 1111111.
  - funct3/funct7 constants.
- Sub-module `rv_encode`: purely combinational (op, rd, rs1, rs2, imm) → 32-bit word. It can be reused in the testbench reference model.

## Test plan
- start; one beat ADDI x1,x0,5 with last=1 → addr0=0x00500093, addr1=0x0000007F, done high 2 cycles after acceptance.
- Back-to-back beats, in_valid held high: ADD x3,x1,x2; SW x2,8(x1); BEQ x1,x2,-4 (last=1) → addresses 0..3 = 0x002081B3, 0x0020A423, 0xFE208EE3, 0x0000007F; one write per cycle.
- JAL x1,8 then HALT with last=0 → 0x008000EF, then 0x0000007F at addr 1; no extra HALT_WR write.
- ADDR_W=2 with 5 beats offered → words at 0..2, HALT at 3, overflow=1, in_ready low after the third acceptance.
- rst_n asserted mid-stream → all outputs return to reset values immediately; a subsequent start writes from addr 0.
- start pulsed during LOAD → ignored, count unchanged; start in DONE → done=0, overflow=0, new program loads from address 0.
